// File: rtl/tenyr_mem_arb.sv
// Shares one single-port synchronous memory between the fetch (i_*) and data (d_*) ports.
// Define TENYR_ARB_RR_EN for round-robin tie-breaking; otherwise the data port always wins ties.
module tenyr_mem_arb #(
    parameter int WAIT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_rw,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    if (WAIT < 0 || WAIT > 15) begin : g_wait_range
        $error("tenyr_mem_arb: WAIT must be in 0..15");
    end

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        sel_d_reg, sel_d_next;
    logic        m_en_reg, m_en_next;
    logic        m_rw_reg, m_rw_next;
    logic [31:0] m_addr_reg, m_addr_next;
    logic [31:0] m_wdata_reg, m_wdata_next;
    logic        i_ack_reg, i_ack_next;
    logic        d_ack_reg, d_ack_next;
    logic [31:0] i_rdata_reg, i_rdata_next;
    logic [31:0] d_rdata_reg, d_rdata_next;
    logic        grant_d;

`ifdef TENYR_ARB_RR_EN
    logic        last_d_reg, last_d_next;

    // On a tie, the port not granted last time wins.
    assign grant_d = d_req && (!i_req || !last_d_reg);
`else
    assign grant_d = d_req;
`endif

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        sel_d_next   = sel_d_reg;
        m_en_next    = m_en_reg;
        m_rw_next    = m_rw_reg;
        m_addr_next  = m_addr_reg;
        m_wdata_next = m_wdata_reg;
        i_ack_next   = 1'b0;
        d_ack_next   = 1'b0;
        i_rdata_next = i_rdata_reg;
        d_rdata_next = d_rdata_reg;
`ifdef TENYR_ARB_RR_EN
        last_d_next  = last_d_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (i_req || d_req) begin
                    sel_d_next = grant_d;
                    m_en_next  = 1'b1;
                    cnt_next   = 4'(WAIT);
                    state_next = BUSY;
`ifdef TENYR_ARB_RR_EN
                    last_d_next = grant_d;
`endif
                    if (grant_d) begin
                        m_rw_next    = d_rw;
                        m_addr_next  = d_addr;
                        m_wdata_next = d_wdata;
                    end else begin
                        m_rw_next    = 1'b0;
                        m_addr_next  = i_addr;
                        m_wdata_next = 32'd0;
                    end
                end
            end
            BUSY: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    // Memory data is valid now; writes leave both read buffers alone.
                    if (!m_rw_reg) begin
                        if (sel_d_reg) d_rdata_next = m_rdata;
                        else           i_rdata_next = m_rdata;
                    end
                    m_en_next  = 1'b0;
                    d_ack_next = sel_d_reg;
                    i_ack_next = !sel_d_reg;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            sel_d_reg   <= 1'b0;
            m_en_reg    <= 1'b0;
            m_rw_reg    <= 1'b0;
            m_addr_reg  <= 32'd0;
            m_wdata_reg <= 32'd0;
            i_ack_reg   <= 1'b0;
            d_ack_reg   <= 1'b0;
            i_rdata_reg <= 32'd0;
            d_rdata_reg <= 32'd0;
`ifdef TENYR_ARB_RR_EN
            last_d_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            sel_d_reg   <= sel_d_next;
            m_en_reg    <= m_en_next;
            m_rw_reg    <= m_rw_next;
            m_addr_reg  <= m_addr_next;
            m_wdata_reg <= m_wdata_next;
            i_ack_reg   <= i_ack_next;
            d_ack_reg   <= d_ack_next;
            i_rdata_reg <= i_rdata_next;
            d_rdata_reg <= d_rdata_next;
`ifdef TENYR_ARB_RR_EN
            last_d_reg  <= last_d_next;
`endif
        end
    end

    assign m_en    = m_en_reg;
    assign m_rw    = m_rw_reg;
    assign m_addr  = m_addr_reg;
    assign m_wdata = m_wdata_reg;
    assign i_ack   = i_ack_reg;
    assign d_ack   = d_ack_reg;
    assign i_rdata = i_rdata_reg;
    assign d_rdata = d_rdata_reg;

endmodule

// File: tb/tb_tenyr_mem_arb.sv
// Directed bench for tenyr_mem_arb: three instances (WAIT = 1, 3, 0), each with a latency-aware memory model.
module tb_tenyr_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n   [3];
    logic        i_req   [3];
    logic [31:0] i_addr  [3];
    logic        i_ack   [3];
    logic [31:0] i_rdata [3];
    logic        d_req   [3];
    logic        d_rw    [3];
    logic [31:0] d_addr  [3];
    logic [31:0] d_wdata [3];
    logic        d_ack   [3];
    logic [31:0] d_rdata [3];
    logic        m_en    [3];
    logic        m_rw    [3];
    logic [31:0] m_addr  [3];
    logic [31:0] m_wdata [3];
    logic [31:0] m_rdata [3];

    logic [31:0] exp_i_rd [3];
    logic [31:0] exp_d_rd [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a ^ 32'hC0DE_0000) + 32'h11;
    endfunction

    function automatic int wt(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 1 : ((gi == 1) ? 3 : 0);
        logic [3:0] en_cnt = 4'd0;

        // Read data only becomes valid W cycles after m_en rises.
        always @(posedge clk) en_cnt <= m_en[gi] ? en_cnt + 4'd1 : 4'd0;
        assign m_rdata[gi] = (m_en[gi] && en_cnt >= 4'(W)) ? memf(m_addr[gi]) : 32'hBAD0BAD0;

        tenyr_mem_arb #(.WAIT(W)) u_dut (
            .clk     (clk),
            .reset_n (rst_n[gi]),
            .i_req   (i_req[gi]),
            .i_addr  (i_addr[gi]),
            .i_ack   (i_ack[gi]),
            .i_rdata (i_rdata[gi]),
            .d_req   (d_req[gi]),
            .d_rw    (d_rw[gi]),
            .d_addr  (d_addr[gi]),
            .d_wdata (d_wdata[gi]),
            .d_ack   (d_ack[gi]),
            .d_rdata (d_rdata[gi]),
            .m_en    (m_en[gi]),
            .m_rw    (m_rw[gi]),
            .m_addr  (m_addr[gi]),
            .m_wdata (m_wdata[gi]),
            .m_rdata (m_rdata[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input int k, input string tag);
        check({tag, ".m_en"},    32'(m_en[k]),  32'd0);
        check({tag, ".m_rw"},    32'(m_rw[k]),  32'd0);
        check({tag, ".m_addr"},  m_addr[k],     32'd0);
        check({tag, ".m_wdata"}, m_wdata[k],    32'd0);
        check({tag, ".i_ack"},   32'(i_ack[k]), 32'd0);
        check({tag, ".d_ack"},   32'(d_ack[k]), 32'd0);
        check({tag, ".i_rdata"}, i_rdata[k],    32'd0);
        check({tag, ".d_rdata"}, d_rdata[k],    32'd0);
    endtask

    // One access starting in an IDLE cycle (called #1 after a rising edge); returns in the following IDLE cycle.
    task automatic access(input int k, input bit is_d, input bit rw, input logic [31:0] addr, input logic [31:0] wd);
        int          w;
        logic        exp_rw;
        logic [31:0] exp_wd;
        w      = wt(k);
        exp_rw = is_d ? rw : 1'b0;
        exp_wd = is_d ? wd : 32'd0;
        if (is_d) begin
            d_req[k] = 1'b1; d_rw[k] = rw; d_addr[k] = addr; d_wdata[k] = wd;
        end else begin
            i_req[k] = 1'b1; i_addr[k] = addr;
        end
        for (int c = 1; c <= w + 3; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                // Operands change after grant and must be ignored.
                d_addr[k] = ~d_addr[k]; d_wdata[k] = ~d_wdata[k]; d_rw[k] = ~d_rw[k]; i_addr[k] = ~i_addr[k];
            end
            check("m_en", 32'(m_en[k]), 32'(c <= w + 1));
            if (c <= w + 1) begin
                check("m_addr",  m_addr[k],     addr);
                check("m_rw",    32'(m_rw[k]),  32'(exp_rw));
                check("m_wdata", m_wdata[k],    exp_wd);
            end
            check("i_ack", 32'(i_ack[k]), 32'(!is_d && c == w + 2));
            check("d_ack", 32'(d_ack[k]), 32'(is_d && c == w + 2));
            if (c == w + 2) begin
                i_req[k] = 1'b0; d_req[k] = 1'b0;
                if (!exp_rw) begin
                    if (is_d) exp_d_rd[k] = memf(addr);
                    else      exp_i_rd[k] = memf(addr);
                end
                check("i_rdata", i_rdata[k], exp_i_rd[k]);
                check("d_rdata", d_rdata[k], exp_d_rd[k]);
            end
        end
        $display("txn dut=%0d port=%s rw=%0d addr=%h wdata=%h i_rdata=%h d_rdata=%h", k, is_d ? "D" : "I",
                 exp_rw, addr, exp_wd, i_rdata[k], d_rdata[k]);
    endtask

    initial begin
        bit exp_seq_d [4];
        int idx;
        int acks;
`ifdef TENYR_ARB_RR_EN
        exp_seq_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_seq_d = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; i_req[k] = 1'b0; i_addr[k] = 32'd0; d_req[k] = 1'b0; d_rw[k] = 1'b0;
            d_addr[k] = 32'd0; d_wdata[k] = 32'd0; exp_i_rd[k] = 32'd0; exp_d_rd[k] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_all_zero(k, "reset");
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

        // WAIT=1
        access(0, 1'b0, 1'b0, 32'h100, 32'h0);
        access(0, 1'b1, 1'b0, 32'h8, 32'h0);
        access(0, 1'b1, 1'b1, 32'h10, 32'hCAFEF00D);

        // WAIT=3
        access(1, 1'b1, 1'b1, 32'h20, 32'h12345678);
        access(1, 1'b0, 1'b0, 32'h104, 32'h0);
        access(1, 1'b1, 1'b0, 32'h40, 32'h0);

        // Reset in the middle of a WAIT=3 read.
        d_req[1] = 1'b1; d_rw[1] = 1'b0; d_addr[1] = 32'h44;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
        end
        rst_n[1] = 1'b0; d_req[1] = 1'b0;
        @(posedge clk); #1;
        check_all_zero(1, "midreset");
        rst_n[1] = 1'b1;
        exp_i_rd[1] = 32'd0; exp_d_rd[1] = 32'd0;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (i_ack[1] || d_ack[1]) acks++;
        end
        check("midreset.no_ack", 32'(acks), 32'd0);
        $display("txn dut=1 mid-access reset acks_after=%0d", acks);

        // WAIT=0 back-to-back
        access(2, 1'b1, 1'b0, 32'h0, 32'h0);
        access(2, 1'b1, 1'b0, 32'h4, 32'h0);
        access(2, 1'b0, 1'b0, 32'h8, 32'h0);
        access(2, 1'b1, 1'b1, 32'hC, 32'h0BADCAFE);

        // Tie on WAIT=1 from a fresh reset: acks land in cycles 3, 7, 11, 15.
        rst_n[0] = 1'b0;
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        exp_i_rd[0] = 32'd0; exp_d_rd[0] = 32'd0;
        i_req[0] = 1'b1; i_addr[0] = 32'h200;
        d_req[0] = 1'b1; d_rw[0] = 1'b0; d_addr[0] = 32'h300; d_wdata[0] = 32'h0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (c % 4 == 3) begin
                idx = (c - 3) / 4;
                check("tie.d_ack", 32'(d_ack[0]), 32'(exp_seq_d[idx]));
                check("tie.i_ack", 32'(i_ack[0]), 32'(!exp_seq_d[idx]));
                if (exp_seq_d[idx]) exp_d_rd[0] = memf(32'h300);
                else                exp_i_rd[0] = memf(32'h200);
                check("tie.d_rdata", d_rdata[0], exp_d_rd[0]);
                check("tie.i_rdata", i_rdata[0], exp_i_rd[0]);
                $display("txn dut=0 tie grant=%0d port=%s", idx, d_ack[0] ? "D" : (i_ack[0] ? "I" : "-"));
                if (c == 11) d_req[0] = 1'b0;
                if (c == 15) i_req[0] = 1'b0;
            end else begin
                check("tie.no_ack", 32'(i_ack[0] | d_ack[0]), 32'd0);
            end
        end
        check("tie.idle_m_en", 32'(m_en[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
